c499_sec_encoder: RTL
=====================

C499_SEC_ENCODER -- requirements
Module: c499_sec_encoder

Interface
- REQ-001 Parameter: LSB_FIRST, default 1, 1 = beat 0 carries d[7:0] (beat k = d[8k+7:8k]); 0 = beat 0 carries d[31:24].
- REQ-002 clk  input  1  sole clock, all state updates on rising edge.
- REQ-003 rst_n  input  1  reset, asynchronous and active-low.
- REQ-004 in_valid  input  1  input beat valid.
- REQ-005 in_ready  output  1  block accepts beat this cycle.
- REQ-006 in_data  input  8  data byte.
- REQ-007 in_abort  input  1  synchronous discard of partially assembled word.
- REQ-008 chk_en  input  1  check enable, sampled with the last beat; 0 forces check bits to 0x00.
- REQ-009 out_valid  output  1  codeword valid.
- REQ-010 out_ready  input  1  downstream accepts codeword.
- REQ-011 out_data  output  32  assembled data word d[31:0].
- REQ-012 out_check  output  8  check bits c[7:0].

Function
- REQ-013 Beat transfer occurs when in_valid && in_ready; exactly 4 beats form one word; a 2-bit beat counter tracks position 0..3 and wraps 3->0.
- REQ-014 Check bits are accumulated per beat (XOR into an 8-bit accumulator) so no 32-bit XOR tree follows the last beat; P() denotes XOR reduction.
- REQ-015 c0=P(d16..23)^d0^d4^d8^d12; c1=P(d24..31)^d1^d5^d9^d13.
- REQ-016 c2=P(d16..19,d24..27)^d2^d6^d10^d14; c3=P(d20..23,d28..31)^d3^d7^d11^d15.
- REQ-017 c4=P(d0..7)^d16^d20^d24^d28; c5=P(d8..15)^d17^d21^d25^d29.
- REQ-018 c6=P(d0..3,d8..11)^d18^d22^d26^d30; c7=P(d4..7,d12..15)^d19^d23^d27^d31.
- REQ-019 Codeword {out_check,out_data} fed to the matching SEC decoder with enable 1 SHALL produce a zero syndrome and unmodified data.
- REQ-020 FSM states: ACC (collecting beats 0..3) and HOLD (output register full, out_valid=1); output register is separate from accumulator.
- REQ-021 Latency: out_valid asserts on the cycle after the 4th beat transfer.
- REQ-022 in_ready = !(beat_cnt==3 && out_valid && !out_ready); beats 0..2 of the next word are accepted while HOLD.
- REQ-023 Simultaneous codeword drain and 4th-beat transfer: new codeword loads, out_valid stays 1, no bubble.
- REQ-024 out_data/out_check SHALL remain stable while out_valid && !out_ready.
- REQ-025 in_abort clears beat counter and accumulator; a beat presented in the same cycle is dropped; output register is unaffected.
- REQ-026 in_abort has priority over a simultaneous beat transfer, including the 4th beat.

Reset
- REQ-027 On rst_n low: out_valid=0, out_data=0, out_check=0, beat counter=0, accumulator=0, state=ACC; in_ready=1 while in reset.
- REQ-028 Reset mid-word discards the partial word; first beat after reset release is beat 0.

Structure
- REQ-029 Shared package holds the 8 check-bit membership masks (32-bit constants, one per c[k]), beat count constant 4, and state enum.
- REQ-030 One sub-module c499_chk_byte: combinational, takes byte, beat index, returns 8-bit partial check contribution.

Verification
- REQ-031 Word 0x00000001, chk_en=1, LSB_FIRST=1 -> out_data=0x00000001, out_check=0x51.
- REQ-032 Word 0x00010000 -> out_check=0x15; word 0x80000000 -> 0x8A; word 0xFFFFFFFF -> 0x00.
- REQ-033 Word 0x00000001 with chk_en=0 -> out_check=0x00; chk_en toggled on beats 0..2 only has no effect.
- REQ-034 out_ready held 0 for 10 cycles with continuous in_valid -> exactly 3 beats accepted, in_ready=0 on beat 3, output stable; out_ready=1 then drains and loads next word back-to-back.
- REQ-035 in_abort after 2 beats, then full word 0x80000000 -> single codeword with out_check=0x8A, no residue from the aborted beats.
- REQ-036 rst_n pulsed low after beat 2 -> all outputs 0 asynchronously; next 4 beats 0x01,0x00,0x00,0x00 -> out_check=0x51.

Source files
------------

// File: rtl/c499_sec_encoder_pkg.sv
// rtl/c499_sec_encoder_pkg.sv - shared constants, state enum and check-bit helper for the SEC encoder
package c499_sec_encoder_pkg;

    localparam int BEATS = 4;
    localparam logic [1:0] LAST_BEAT = 2'(BEATS - 1);

    typedef enum logic {
        ST_ACC  = 1'b0,
        ST_HOLD = 1'b1
    } state_e;

    // Bit k of the check byte is the parity of the data bits selected by CHK_MASK[k].
    localparam logic [31:0] CHK_MASK [8] = '{
        32'h00FF_1111,
        32'hFF00_2222,
        32'h0F0F_4444,
        32'hF0F0_8888,
        32'h1111_00FF,
        32'h2222_FF00,
        32'h4444_0F0F,
        32'h8888_F0F0
    };

    function automatic logic [7:0] chk_of_word(input logic [31:0] word);
        logic [7:0] chk;
        chk = '0;
        for (int k = 0; k < 8; k++) begin
            chk[k] = ^(word & CHK_MASK[k]);
        end
        return chk;
    endfunction

endpackage

// File: rtl/c499_chk_byte.sv
// rtl/c499_chk_byte.sv - check-bit contribution of one data byte at a given beat position
module c499_chk_byte
    import c499_sec_encoder_pkg::*;
#(
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic [7:0] data_byte,
    input  logic [1:0] beat_idx,
    output logic [7:0] chk_part
);

    logic [1:0]  lane;
    logic [31:0] placed;

    always_comb begin
        lane     = LSB_FIRST ? beat_idx : (LAST_BEAT - beat_idx);
        placed   = 32'(data_byte) << {lane, 3'b000};
        chk_part = chk_of_word(placed);
    end

endmodule

// File: rtl/c499_sec_encoder.sv
// rtl/c499_sec_encoder.sv - byte-serial SEC encoder: assembles 4 beats into a 32-bit word plus 8 check bits
module c499_sec_encoder
    import c499_sec_encoder_pkg::*;
#(
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  in_data,
    input  logic        in_abort,
    input  logic        chk_en,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic [7:0]  out_check
);

    state_e      state_q, state_d;
    logic [1:0]  beat_cnt_q, beat_cnt_d;
    logic [7:0]  acc_q, acc_d;
    logic [31:0] word_q, word_d;
    logic [31:0] out_data_q, out_data_d;
    logic [7:0]  out_check_q, out_check_d;

    logic [1:0]  lane;
    logic [31:0] merged;
    logic [7:0]  chk_part;
    logic        beat_fire;
    logic        last_beat;

    c499_chk_byte #(
        .LSB_FIRST(LSB_FIRST)
    ) u_chk_byte (
        .data_byte(in_data),
        .beat_idx (beat_cnt_q),
        .chk_part (chk_part)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_ACC;
            beat_cnt_q  <= '0;
            acc_q       <= '0;
            word_q      <= '0;
            out_data_q  <= '0;
            out_check_q <= '0;
        end else begin
            state_q     <= state_d;
            beat_cnt_q  <= beat_cnt_d;
            acc_q       <= acc_d;
            word_q      <= word_d;
            out_data_q  <= out_data_d;
            out_check_q <= out_check_d;
        end
    end

    // Only the 4th beat can be blocked: beats 0..2 go into the accumulator, not the held codeword.
    always_comb begin
        out_valid = (state_q == ST_HOLD);
        in_ready  = !((beat_cnt_q == LAST_BEAT) && out_valid && !out_ready);
        out_data  = out_data_q;
        out_check = out_check_q;
    end

    always_comb begin
        beat_fire = in_valid && in_ready && !in_abort;
        last_beat = beat_fire && (beat_cnt_q == LAST_BEAT);
        lane      = LSB_FIRST ? beat_cnt_q : (LAST_BEAT - beat_cnt_q);
        merged    = (word_q & ~(32'h0000_00FF << {lane, 3'b000}))
                  | (32'(in_data) << {lane, 3'b000});
    end

    always_comb begin
        beat_cnt_d  = beat_cnt_q;
        acc_d       = acc_q;
        word_d      = word_q;
        out_data_d  = out_data_q;
        out_check_d = out_check_q;
        if (in_abort) begin
            beat_cnt_d = '0;
            acc_d      = '0;
            word_d     = '0;
        end else if (beat_fire) begin
            beat_cnt_d = beat_cnt_q + 2'd1;
            if (last_beat) begin
                acc_d       = '0;
                word_d      = '0;
                out_data_d  = merged;
                out_check_d = chk_en ? (acc_q ^ chk_part) : 8'h00;
            end else begin
                acc_d  = acc_q ^ chk_part;
                word_d = merged;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_ACC:  if (last_beat) state_d = ST_HOLD;
            ST_HOLD: if (!last_beat && out_ready) state_d = ST_ACC;
            default: state_d = ST_ACC;
        endcase
    end

endmodule
